calc_param: RTL and testbench
=============================

Name: calc_param

Overview:
- Parametrised successor of the single-width keypad calculator.
- Accepts 4-bit keypad commands under a valid/ready handshake and builds two operands in decimal.
- Computes add, subtract, multiply and divide (multi-cycle shift-add and restoring divide).
- Streams the decimal result digit by digit onto a multiplexed display bus (data/pos), adding a sign flag, overflow detection and a divide-by-zero error.

Parameters:
- NUM_DIGITS, 8, display digits; operand/result magnitude is limited to MAX = 10^NUM_DIGITS - 1.
- WIDTH, 27, operand register width; must satisfy 2^WIDTH > MAX.
- POS_W, 4, width of pos; must satisfy 2^POS_W >= NUM_DIGITS.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- cmd  in  4  command: 0-9 digit, 1010 add, 1011 sub, 1100 mul, 1101 div, 1110 equals, 1111 backspace.
- cmd_valid  in  1  cmd is presented this cycle.
- status  out  2  00 error, 01 busy, 10 ready.
- data  out  4  BCD digit being displayed.
- pos  out  POS_W  display position of data (0 = least significant).
- data_valid  out  1  data/pos are valid this cycle.
- neg  out  1  displayed value is negative.

Behaviour:
- Reset (reset==0 at a clock edge) values:
  - Outputs: status=10, data=0, pos=0, data_valid=0, neg=0.
  - Internal: state=ENTRY_A; acc, regA, regB, op and fresh all 0.
  - Reset mid-calc or mid-print aborts immediately.
- Handshake:
  - A command is accepted only on a cycle where cmd_valid=1 and status==10.
  - It is ignored otherwise, including in ERROR.
  - Every accepted command forces status=01 on the next cycle.
- States: ENTRY_A, ENTRY_B, CALC, PRINT, ERROR. ret records the state to return to after PRINT.
- ENTRY_A, on an accepted command:
  - Digit d:
    - If fresh=1: acc=d, neg=0, fresh=0.
    - Otherwise acc=acc*10+d, but only if the result is <= MAX; if it would exceed MAX, acc is unchanged.
    - Goes to PRINT with ret=ENTRY_A.
  - Backspace: acc=acc/10, fresh=0; goes to PRINT with ret=ENTRY_A.
  - Operator (1010-1101):
    - If neg=1, goes to ERROR (negative operands are unsupported).
    - Otherwise regA=acc, op=cmd, acc=0, b_entered=0; goes to PRINT with ret=ENTRY_B.
  - Equals: no change; goes to PRINT with ret=ENTRY_A.
- ENTRY_B, on an accepted command:
  - Digit and backspace: same as in ENTRY_A; any digit sets b_entered=1.
  - Operator:
    - If b_entered=0, replaces op; goes to PRINT with ret=ENTRY_B.
    - If b_entered=1, goes to ERROR.
  - Equals: regB=acc; goes to CALC.
- CALC:
  - Add: one cycle. If regA+regB > MAX, goes to ERROR.
  - Sub: one cycle.
    - If regA >= regB: acc=regA-regB, neg=0.
    - Otherwise acc=regB-regA, neg=1.
  - Mul: iterative shift-add, exactly WIDTH cycles, 2*WIDTH-bit product. If product > MAX, goes to ERROR.
  - Div: restoring division, exactly WIDTH cycles, quotient only (remainder discarded). If regB==0, goes to ERROR in the first CALC cycle.
  - On completion: acc=result, fresh=1; goes to PRINT with ret=ENTRY_A. The result therefore becomes operand A for chaining.
- PRINT: runs NUM_DIGITS consecutive cycles, k = 0 .. NUM_DIGITS-1.
  - Each cycle: data = decimal digit k of acc, pos=k, data_valid=1. Leading zeros are printed.
  - The cycle after k=NUM_DIGITS-1: data_valid=0, pos=0, status=10, state=ret.
  - Total latency for a digit, backspace or operator command, acceptance to ready: NUM_DIGITS+1 cycles.
- ERROR:
  - status=00, data_valid=0, data=0.
  - Held until reset; cmd is ignored.
- Status is 01 throughout CALC and PRINT.

Test Plan:
- Reset, then digits 1,2,3 with one-cycle cmd_valid pulses, each sent when status==10 → after each, 8 data_valid cycles. Final sweep emits pos0=3, pos1=2, pos2=1, pos3..7=0; status returns to 10.
- 12 + 34 = → regA=12, regB=34; sweep shows 46, neg=0. Then 5 (fresh) → display 5.
- 7 - 9 = → display 2 with neg=1. Then operator 1010 → status=00 (ERROR); status stays 00 until reset.
- 1234 * 5678 = → status busy for 27 CALC cycles plus the sweep; display 07006652. Then 99999999 * 2 = → ERROR.
- 100 / 7 = → display 14. 5 / 0 = → ERROR on the first CALC cycle.
- Backspace and boundaries:
  - 9 digits of 9 → ninth digit ignored, display 99999999.
  - Backspace → 9999999.
  - cmd_valid held while busy → ignored.
  - Reset asserted mid-multiply → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/calc_param.sv
// calc_param: keypad calculator with configurable display width.
// Builds two decimal operands from 4-bit keypad commands (valid/ready
// handshake via status), computes add/sub/mul/div (mul and div are
// iterative over WIDTH cycles), then sweeps the result digit by digit
// onto the display bus.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-low reset
//   cmd         0-9 digit, 1010 add, 1011 sub, 1100 mul, 1101 div,
//               1110 equals, 1111 backspace
//   cmd_valid   cmd presented this cycle (taken only when status==10)
//   status      00 error, 01 busy, 10 ready
//   data        BCD digit being displayed
//   pos         display position of data (0 = least significant)
//   data_valid  data/pos valid this cycle
//   neg         displayed value is negative
module calc_param #(
  parameter int NUM_DIGITS = 8,
  parameter int WIDTH      = 27,
  parameter int POS_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       cmd,
  input  logic             cmd_valid,
  output logic [1:0]       status,
  output logic [3:0]       data,
  output logic [POS_W-1:0] pos,
  output logic             data_valid,
  output logic             neg
);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [WIDTH-1:0] MAX = WIDTH'(pow10(NUM_DIGITS) - 1);
  localparam int CNT_W = ($clog2(WIDTH) > POS_W) ? $clog2(WIDTH) : POS_W;

  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_DIV = 4'b1101;
  localparam logic [3:0] C_EQ   = 4'b1110;
  localparam logic [3:0] C_BS   = 4'b1111;

  typedef enum logic [2:0] {ENTRY_A, ENTRY_B, CALC, PRINT, ERROR} state_e;

  state_e               state_q, state_d, ret_q, ret_d;
  logic [WIDTH-1:0]     acc_q, acc_d, rega_q, rega_d, regb_q, regb_d;
  logic [WIDTH-1:0]     pr_q, pr_d, sh_q, sh_d;
  logic [2*WIDTH-1:0]   wr_q, wr_d;
  logic [3:0]           op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 fresh_q, fresh_d, neg_q, neg_d, bent_q, bent_d;

  // Datapath helpers
  logic [WIDTH+3:0]     acc_x10;
  logic [WIDTH-1:0]     digit_acc;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_rem;
  logic                 div_ge, last, done;
  logic [WIDTH-1:0]     res, q_next;

  assign acc_x10 = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{WIDTH{1'b0}}, cmd};
  // A digit that would push the operand past MAX is dropped silently.
  assign digit_acc = fresh_q ? {{(WIDTH-4){1'b0}}, cmd}
                   : (acc_x10 <= {4'b0, MAX}) ? acc_x10[WIDTH-1:0] : acc_q;

  assign sum = {1'b0, rega_q} + {1'b0, regb_q};

  // Shift-add multiply: multiplier (sh_q) consumed MSB first.
  assign mul_next = {wr_q[2*WIDTH-2:0], 1'b0}
                  + (sh_q[WIDTH-1] ? {{WIDTH{1'b0}}, rega_q} : {(2*WIDTH){1'b0}});

  // Restoring divide: dividend bits shift out of sh_q, quotient bits in.
  assign div_shift = {wr_q[WIDTH-1:0], sh_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, regb_q};
  assign div_rem   = div_ge ? div_shift - {1'b0, regb_q} : div_shift;
  assign q_next    = {sh_q[WIDTH-2:0], div_ge};

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    acc_d   = acc_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    op_d    = op_q;
    fresh_d = fresh_q;
    neg_d   = neg_q;
    bent_d  = bent_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    sh_d    = sh_q;
    wr_d    = wr_q;
    done    = 1'b0;
    res     = '0;
    unique case (state_q)
      ENTRY_A, ENTRY_B: begin
        if (cmd_valid) begin
          state_d = PRINT;
          ret_d   = state_q;
          cnt_d   = '0;
          if (cmd < 4'd10) begin
            acc_d   = digit_acc;
            if (fresh_q) neg_d = 1'b0;
            fresh_d = 1'b0;
            if (state_q == ENTRY_B) bent_d = 1'b1;
          end else if (cmd == C_BS) begin
            acc_d   = acc_q / WIDTH'(10);
            fresh_d = 1'b0;
          end else if (cmd == C_EQ) begin
            if (state_q == ENTRY_B) begin
              regb_d  = acc_q;
              state_d = CALC;
              sh_d    = (op_q == OP_DIV) ? rega_q : acc_q;
              wr_d    = '0;
            end
          end else if (state_q == ENTRY_A) begin
            if (neg_q) begin
              state_d = ERROR;
            end else begin
              rega_d = acc_q;
              op_d   = cmd;
              acc_d  = '0;
              bent_d = 1'b0;
              ret_d  = ENTRY_B;
            end
          end else begin
            // Operator in ENTRY_B: retype the operator until B has digits.
            if (bent_q) state_d = ERROR;
            else        op_d    = cmd;
          end
          pr_d = acc_d;
        end
      end
      CALC: begin
        if (op_q == OP_ADD) begin
          if (sum > {1'b0, MAX}) state_d = ERROR;
          else begin done = 1'b1; res = sum[WIDTH-1:0]; neg_d = 1'b0; end
        end else if (op_q == OP_SUB) begin
          done = 1'b1;
          if (rega_q >= regb_q) begin res = rega_q - regb_q; neg_d = 1'b0; end
          else                  begin res = regb_q - rega_q; neg_d = 1'b1; end
        end else if (op_q == OP_MUL) begin
          wr_d  = mul_next;
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            if (mul_next > {{WIDTH{1'b0}}, MAX}) state_d = ERROR;
            else begin done = 1'b1; res = mul_next[WIDTH-1:0]; neg_d = 1'b0; end
          end
        end else begin
          if (regb_q == '0) begin
            state_d = ERROR;
          end else begin
            wr_d  = {{(WIDTH-1){1'b0}}, div_rem};
            sh_d  = q_next;
            cnt_d = cnt_q + 1'b1;
            if (last) begin done = 1'b1; res = q_next; neg_d = 1'b0; end
          end
        end
        if (done) begin
          acc_d   = res;
          pr_d    = res;
          fresh_d = 1'b1;
          state_d = PRINT;
          ret_d   = ENTRY_A;
          cnt_d   = '0;
        end
      end
      PRINT: begin
        // pr_q is divided by ten each cycle so its low digit is always current.
        pr_d = pr_q / WIDTH'(10);
        if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
          cnt_d   = '0;
          state_d = ret_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ENTRY_A;
      ret_q   <= ENTRY_A;
      acc_q   <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
      op_q    <= '0;
      fresh_q <= 1'b0;
      neg_q   <= 1'b0;
      bent_q  <= 1'b0;
      cnt_q   <= '0;
      pr_q    <= '0;
      sh_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      acc_q   <= acc_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      op_q    <= op_d;
      fresh_q <= fresh_d;
      neg_q   <= neg_d;
      bent_q  <= bent_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      sh_q    <= sh_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    status     = 2'b10;
    data       = 4'd0;
    pos        = '0;
    data_valid = 1'b0;
    unique case (state_q)
      ERROR: status = 2'b00;
      CALC:  status = 2'b01;
      PRINT: begin
        status     = 2'b01;
        data_valid = 1'b1;
        data       = 4'(pr_q % WIDTH'(10));
        pos        = POS_W'(cnt_q);
      end
      default: status = 2'b10;
    endcase
  end

  assign neg = neg_q;

endmodule

// File: tb/tb_calc_param.sv
// Directed testbench for calc_param: operand entry, the four operations,
// display sweeps, error paths, busy-time command rejection and mid-calc reset.
module tb_calc_param;
  localparam int ND = 8;
  localparam int W  = 27;
  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    cmd = 4'd0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    status;
  logic [3:0]    data;
  logic [PW-1:0] pos;
  logic          data_valid;
  logic          neg;

  int checks = 0;
  int errors = 0;

  calc_param #(.NUM_DIGITS(ND), .WIDTH(W), .POS_W(PW)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .status(status), .data(data), .pos(pos), .data_valid(data_valid), .neg(neg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic press(input logic [3:0] c);
    int n;
    n = 0;
    while (status !== 2'b10 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) chk("ready_timeout", 32'(status), 32'd2);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // Checks the full sweep starting at the current negedge (digit 0 visible).
  task automatic sweep(input string tag, input int val, input logic exp_neg);
    int p;
    p = 1;
    chk({tag, "_neg"}, 32'(neg), 32'(exp_neg));
    for (int k = 0; k < ND; k++) begin
      chk({tag, "_dv"}, 32'(data_valid), 32'd1);
      chk({tag, "_pos"}, 32'(pos), 32'(k));
      chk({tag, "_data"}, 32'(data), 32'((val / p) % 10));
      p = p * 10;
      @(negedge clock);
    end
    chk({tag, "_end_dv"}, 32'(data_valid), 32'd0);
    chk({tag, "_end_status"}, 32'(status), 32'd2);
  endtask

  task automatic press_sweep(input logic [3:0] c, input string tag, input int val,
                             input logic exp_neg);
    press(c);
    sweep(tag, val, exp_neg);
  endtask

  // Counts busy cycles from the first CALC cycle until a sweep or ERROR.
  task automatic calc_wait(output int n);
    n = 0;
    while (data_valid !== 1'b1 && status !== 2'b00 && n < 100) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    int n;
    int v;
    @(negedge clock);
    do_reset();
    chk("rst_status", 32'(status), 32'd2);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);

    // Digit entry 1,2,3
    press_sweep(4'd1, "d1", 1, 1'b0);
    press_sweep(4'd2, "d12", 12, 1'b0);
    press_sweep(4'd3, "d123", 123, 1'b0);

    // 12 + 34 = 46, then fresh 5
    do_reset();
    press_sweep(4'd1, "a1", 1, 1'b0);
    press_sweep(4'd2, "a12", 12, 1'b0);
    press_sweep(4'b1010, "a_op", 0, 1'b0);
    press_sweep(4'd3, "a3", 3, 1'b0);
    press_sweep(4'd4, "a34", 34, 1'b0);
    press(4'b1110);
    calc_wait(n);
    chk("add_cycles", 32'(n), 32'd1);
    sweep("add46", 46, 1'b0);
    press_sweep(4'd5, "fresh5", 5, 1'b0);

    // 7 - 9 = -2, then operator on a negative operand
    do_reset();
    press_sweep(4'd7, "s7", 7, 1'b0);
    press_sweep(4'b1011, "s_op", 0, 1'b0);
    press_sweep(4'd9, "s9", 9, 1'b0);
    press(4'b1110);
    calc_wait(n);
    chk("sub_cycles", 32'(n), 32'd1);
    sweep("sub_m2", 2, 1'b1);
    press(4'b1010);
    chk("neg_op_err", 32'(status), 32'd0);
    cmd = 4'd1;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clock);
    cmd_valid = 1'b0;
    chk("err_hold_status", 32'(status), 32'd0);
    chk("err_hold_dv", 32'(data_valid), 32'd0);
    chk("err_hold_data", 32'(data), 32'd0);

    // 1234 * 5678 = 7006652
    do_reset();
    press_sweep(4'd1, "m1", 1, 1'b0);
    press_sweep(4'd2, "m12", 12, 1'b0);
    press_sweep(4'd3, "m123", 123, 1'b0);
    press_sweep(4'd4, "m1234", 1234, 1'b0);
    press_sweep(4'b1100, "m_op", 0, 1'b0);
    press_sweep(4'd5, "m5", 5, 1'b0);
    press_sweep(4'd6, "m56", 56, 1'b0);
    press_sweep(4'd7, "m567", 567, 1'b0);
    press_sweep(4'd8, "m5678", 5678, 1'b0);
    press(4'b1110);
    calc_wait(n);
    chk("mul_cycles", 32'(n), 32'd27);
    sweep("mul_res", 7006652, 1'b0);

    // Nine 9s (ninth ignored) then * 2 overflows
    do_reset();
    v = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) v = v * 10 + 9;
      press_sweep(4'd9, "nines", v, 1'b0);
    end
    press_sweep(4'b1100, "ovf_op", 0, 1'b0);
    press_sweep(4'd2, "ovf2", 2, 1'b0);
    press(4'b1110);
    calc_wait(n);
    chk("mul_ovf_cycles", 32'(n), 32'd27);
    chk("mul_ovf_err", 32'(status), 32'd0);

    // Nine 9s then backspace
    do_reset();
    v = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) v = v * 10 + 9;
      press_sweep(4'd9, "nines_b", v, 1'b0);
    end
    press_sweep(4'b1111, "bksp", 9999999, 1'b0);

    // 100 / 7 = 14, then 5 / 0
    do_reset();
    press_sweep(4'd1, "v1", 1, 1'b0);
    press_sweep(4'd0, "v10", 10, 1'b0);
    press_sweep(4'd0, "v100", 100, 1'b0);
    press_sweep(4'b1101, "v_op", 0, 1'b0);
    press_sweep(4'd7, "v7", 7, 1'b0);
    press(4'b1110);
    calc_wait(n);
    chk("div_cycles", 32'(n), 32'd27);
    sweep("div14", 14, 1'b0);
    press_sweep(4'd5, "z5", 5, 1'b0);
    press_sweep(4'b1101, "z_op", 0, 1'b0);
    press_sweep(4'd0, "z0", 0, 1'b0);
    press(4'b1110);
    calc_wait(n);
    chk("div0_cycles", 32'(n), 32'd1);
    chk("div0_err", 32'(status), 32'd0);

    // cmd_valid held while busy: only the first command is taken
    do_reset();
    cmd = 4'd1;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd = 4'd2;
    for (int k = 0; k < ND; k++) begin
      chk("busy_dv", 32'(data_valid), 32'd1);
      chk("busy_data", 32'(data), (k == 0) ? 32'd1 : 32'd0);
      if (k == ND - 1) cmd_valid = 1'b0;
      @(negedge clock);
    end
    chk("busy_end_status", 32'(status), 32'd2);
    press_sweep(4'b1110, "busy_eq", 1, 1'b0);

    // Reset in the middle of a multiply
    do_reset();
    press_sweep(4'd3, "r3", 3, 1'b0);
    press_sweep(4'b1100, "r_op", 0, 1'b0);
    press_sweep(4'd3, "r3b", 3, 1'b0);
    press(4'b1110);
    repeat (5) @(negedge clock);
    chk("midmul_busy", 32'(status), 32'd1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst_status", 32'(status), 32'd2);
    chk("midrst_dv", 32'(data_valid), 32'd0);
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_pos", 32'(pos), 32'd0);
    chk("midrst_neg", 32'(neg), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    press_sweep(4'b1110, "midrst_acc", 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
